// File: rtl/am_lock_rx.sv
// Alignment marker lock and removal for one 40GBASE-R receive lane.
// Finds the periodic marker, identifies its transmit lane and flags every marker slot for removal.
module am_lock_rx #(
    parameter int HEAD_W  = 2,
    parameter int DATA_W  = 64,
    parameter int GAP_W   = 14,
    parameter int INV_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [HEAD_W-1:0] head_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [HEAD_W-1:0] head_o,
    output logic [DATA_W-1:0] data_o,
    output logic              marker_v_o,
    output logic              lock_v_o,
    output logic [1:0]        lane_o,
    output logic              am_err_o
);

    // state   | meaning
    // SEARCH  | compare every valid block against all four lane markers
    // CONFIRM | one candidate seen; only the expected slot is compared
    // LOCKED  | every expected slot is a marker; count consecutive bad ones
    typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

    // Key is {bytes 6,5,4, bytes 2,1,0}; BIP bytes 3 and 7 are not part of it.
    localparam logic [47:0] AM_L0 = {24'hB8896F, 24'h477690};
    localparam logic [47:0] AM_L1 = {24'h193B0F, 24'hE6C4F0};
    localparam logic [47:0] AM_L2 = {24'h649A3A, 24'h9B65C5};
    localparam logic [47:0] AM_L3 = {24'hC2865D, 24'h3D79A2};

    state_t              state_q, state_d;
    logic [GAP_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          cand_q, cand_d;
    logic [1:0]          lane_q, lane_d;
    logic [1:0]          inv_q, inv_d;
    logic                lock_q, lock_d;
    logic                marker_q, marker_d;
    logic                err_q, err_d;
    logic                valid_q, valid_d;
    logic [HEAD_W-1:0]   head_q, head_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic [47:0]         key;
    logic                head_ok;
    logic [3:0]          match;
    logic                any_match;
    logic [1:0]          match_lane;
    logic                at_slot;
    logic                restart;

    assign key     = {data_i[55:32], data_i[23:0]};
    assign head_ok = (head_i == HEAD_W'(1));
    assign at_slot = (cnt_q == '1);

    always_comb begin
        match[0] = head_ok && (key == AM_L0);
        match[1] = head_ok && (key == AM_L1);
        match[2] = head_ok && (key == AM_L2);
        match[3] = head_ok && (key == AM_L3);
        any_match  = |match;
        match_lane = 2'd0;
        if (match[1]) match_lane = 2'd1;
        if (match[2]) match_lane = 2'd2;
        if (match[3]) match_lane = 2'd3;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        lane_d   = lane_q;
        inv_d    = inv_q;
        lock_d   = lock_q;
        marker_d = 1'b0;
        err_d    = 1'b0;
        restart  = 1'b0;
        valid_d  = valid_i;
        head_d   = head_i;
        data_d   = data_i;

        if (valid_i) begin
            cnt_d = cnt_q + GAP_W'(1);
            unique case (state_q)
                SEARCH: begin
                    restart = 1'b1;
                end
                CONFIRM: begin
                    if (at_slot) begin
                        if (match[cand_q]) begin
                            state_d  = LOCKED;
                            lock_d   = 1'b1;
                            lane_d   = cand_q;
                            inv_d    = 2'd0;
                            marker_d = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            restart = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (at_slot) begin
                        marker_d = 1'b1;
                        cnt_d    = '0;
                        if (match[lane_q]) begin
                            inv_d = 2'd0;
                        end else begin
                            err_d = 1'b1;
                            if (inv_q != 2'b11) inv_d = inv_q + 2'd1;
                            if (int'(inv_q) + 1 >= INV_MAX) begin
                                state_d = SEARCH;
                                lock_d  = 1'b0;
                            end
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase

            // A failed confirmation slot is treated exactly like a search block.
            if (restart) begin
                if (any_match) begin
                    state_d  = CONFIRM;
                    cand_d   = match_lane;
                    cnt_d    = '0;
                    marker_d = 1'b1;
                end else begin
                    state_d = SEARCH;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SEARCH;
            cnt_q    <= '0;
            cand_q   <= 2'd0;
            lane_q   <= 2'd0;
            inv_q    <= 2'd0;
            lock_q   <= 1'b0;
            marker_q <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            head_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            lane_q   <= lane_d;
            inv_q    <= inv_d;
            lock_q   <= lock_d;
            marker_q <= marker_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
            data_q   <= data_d;
        end
    end

    assign valid_o    = valid_q;
    assign head_o     = head_q;
    assign data_o     = data_q;
    assign marker_v_o = marker_q;
    assign lock_v_o   = lock_q;
    assign lane_o     = lane_q;
    assign am_err_o   = err_q;

endmodule

// File: tb/tb_am_lock_rx.sv
// Bench for am_lock_rx: directed scenarios with random filler, checked every cycle against a marker-rule model.
module tb_am_lock_rx;

    localparam int GAP_W   = 8;
    localparam int PERIOD  = 1 << GAP_W;
    localparam int INV_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic [1:0]  head_i;
    logic [63:0] data_i;
    logic        valid_o;
    logic [1:0]  head_o;
    logic [63:0] data_o;
    logic        marker_v_o;
    logic        lock_v_o;
    logic [1:0]  lane_o;
    logic        am_err_o;

    int checks = 0;
    int errors = 0;

    am_lock_rx #(
        .HEAD_W (2),
        .DATA_W (64),
        .GAP_W  (GAP_W),
        .INV_MAX(INV_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid_i),
        .head_i    (head_i),
        .data_i    (data_i),
        .valid_o   (valid_o),
        .head_o    (head_o),
        .data_o    (data_o),
        .marker_v_o(marker_v_o),
        .lock_v_o  (lock_v_o),
        .lane_o    (lane_o),
        .am_err_o  (am_err_o)
    );

    always #5 clk = ~clk;

    // Marker bytes per lane, in order of byte positions 0,1,2,4,5,6.
    logic [7:0] am_bytes [4][6] = '{
        '{8'h90, 8'h76, 8'h47, 8'h6F, 8'h89, 8'hB8},
        '{8'hF0, 8'hC4, 8'hE6, 8'h0F, 8'h3B, 8'h19},
        '{8'hC5, 8'h65, 8'h9B, 8'h3A, 8'h9A, 8'h64},
        '{8'hA2, 8'h79, 8'h3D, 8'h5D, 8'h86, 8'hC2}
    };

    // Reference model: blocks since last accepted marker, candidate/lock flags, bad-slot run.
    bit   m_locked  = 0;
    bit   m_cand_ok = 0;
    int   m_cand    = 0;
    int   m_lane    = 0;
    int   m_since   = 0;
    int   m_bad     = 0;
    logic        e_valid, e_mark, e_lock, e_err;
    logic [1:0]  e_head, e_lane;
    logic [63:0] e_data;

    function automatic logic [63:0] mk(input int l, input logic [7:0] b3, input logic [7:0] b7);
        logic [63:0] d;
        d = '0;
        for (int k = 0; k < 6; k++) begin
            int pos;
            pos = (k < 3) ? k : k + 1;
            d[pos*8 +: 8] = am_bytes[l][k];
        end
        d[31:24] = b3;
        d[63:56] = b7;
        return d;
    endfunction

    function automatic int lane_of(input logic [1:0] h, input logic [63:0] d);
        if (h != 2'b01) return -1;
        for (int l = 0; l < 4; l++) begin
            bit ok;
            ok = 1;
            for (int k = 0; k < 6; k++) begin
                int pos;
                pos = (k < 3) ? k : k + 1;
                if (d[pos*8 +: 8] != am_bytes[l][k]) ok = 0;
            end
            if (ok) return l;
        end
        return -1;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic model(input logic r, input logic v, input logic [1:0] h, input logic [63:0] d);
        int l;
        bit slot;
        if (r) begin
            m_locked = 0; m_cand_ok = 0; m_cand = 0; m_lane = 0; m_since = 0; m_bad = 0;
            e_valid = 0; e_head = 0; e_data = 0; e_mark = 0; e_err = 0; e_lock = 0; e_lane = 0;
            return;
        end
        e_valid = v; e_head = h; e_data = d; e_mark = 0; e_err = 0;
        if (v) begin
            l = lane_of(h, d);
            m_since++;
            slot = (m_since % PERIOD) == 0;
            if (m_locked) begin
                if (slot) begin
                    e_mark = 1;
                    if (l == m_lane) m_bad = 0;
                    else begin
                        e_err = 1;
                        m_bad++;
                        if (m_bad >= INV_MAX) begin
                            m_locked = 0;
                            m_cand_ok = 0;
                        end
                    end
                end
            end else if (m_cand_ok && slot && l == m_cand) begin
                m_locked = 1; m_lane = m_cand; m_bad = 0; m_since = 0; e_mark = 1;
            end else if (!m_cand_ok || slot) begin
                m_cand_ok = (l >= 0);
                if (l >= 0) begin
                    m_cand = l; m_since = 0; e_mark = 1;
                end
            end
        end
        e_lock = m_locked;
        e_lane = 2'(m_lane);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [1:0] h, input logic [63:0] d);
        reset = r; valid_i = v; head_i = h; data_i = d;
        model(r, v, h, d);
        @(posedge clk);
        #1;
        chk("valid_o",    valid_o,    e_valid);
        chk("head_o",     head_o,     e_head);
        chk("data_o",     data_o,     e_data);
        chk("marker_v_o", marker_v_o, e_mark);
        chk("lock_v_o",   lock_v_o,   e_lock);
        chk("lane_o",     lane_o,     e_lane);
        chk("am_err_o",   am_err_o,   e_err);
    endtask

    task automatic blk(input logic [1:0] h, input logic [63:0] d);
        step(1'b0, 1'b1, h, d);
    endtask

    task automatic marker(input int l);
        blk(2'b01, mk(l, 8'($urandom), 8'($urandom)));
    endtask

    // n valid filler blocks, optionally interleaved with idle cycles.
    task automatic fill(input int n, input bit gaps);
        int done;
        done = 0;
        while (done < n) begin
            if (gaps && $urandom_range(3) == 0) begin
                step(1'b0, 1'b0, 2'($urandom), rnd64());
            end else begin
                blk($urandom_range(1) ? 2'b01 : 2'b10, rnd64());
                done++;
            end
        end
    endtask

    initial begin
        logic [63:0] m2;
        reset = 1'b1; valid_i = 1'b0; head_i = 2'b00; data_i = '0;

        repeat (3) step(1'b1, 1'b0, 2'b00, 64'd0);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_lock",  lock_v_o, 1'b0);

        // Acquire on lane 2
        marker(2);
        chk("acq_m1_flag", marker_v_o, 1'b1);
        chk("acq_m1_lock", lock_v_o, 1'b0);
        fill(PERIOD - 1, 0);
        m2 = mk(2, 8'($urandom), 8'($urandom));
        blk(2'b01, m2);
        chk("acq_m2_flag", marker_v_o, 1'b1);
        chk("acq_lock",    lock_v_o, 1'b1);
        chk("acq_lane",    lane_o, 2'd2);
        chk("acq_data",    data_o, m2);

        // Reset pulse while locked
        fill(10, 0);
        step(1'b1, 1'b1, 2'b01, mk(2, 8'h00, 8'h00));
        chk("rst_mid_valid",  valid_o, 1'b0);
        chk("rst_mid_marker", marker_v_o, 1'b0);
        chk("rst_mid_lock",   lock_v_o, 1'b0);
        chk("rst_mid_lane",   lane_o, 2'd0);
        chk("rst_mid_data",   data_o, 64'd0);
        marker(2);
        chk("relock_first", lock_v_o, 1'b0);
        fill(PERIOD - 1, 0);
        marker(2);
        chk("relock_second", lock_v_o, 1'b1);

        // Wrong spacing, then wrong lane at the slot restarts confirmation
        step(1'b1, 1'b0, 2'b00, 64'd0);
        marker(0);
        fill(PERIOD - 2, 0);
        marker(0);
        chk("early_not_flagged", marker_v_o, 1'b0);
        marker(1);
        chk("wrong_lane_flag", marker_v_o, 1'b1);
        chk("wrong_lane_lock", lock_v_o, 1'b0);
        fill(PERIOD - 1, 0);
        marker(1);
        chk("l1_lock", lock_v_o, 1'b1);
        chk("l1_lane", lane_o, 2'd1);

        // Header check in SEARCH
        step(1'b1, 1'b0, 2'b00, 64'd0);
        blk(2'b10, mk(0, 8'h11, 8'h22));
        chk("bad_head_flag", marker_v_o, 1'b0);
        fill(5, 0);
        marker(0);
        chk("still_search", marker_v_o, 1'b1);

        // Valid gaps during acquisition on lane 3, then loss of lock
        step(1'b1, 1'b0, 2'b00, 64'd0);
        marker(3);
        fill(PERIOD - 1, 1);
        marker(3);
        chk("gap_lock", lock_v_o, 1'b1);
        chk("gap_lane", lane_o, 2'd3);
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                fill(50, 0);
                marker(3);
                chk("midperiod_ignored", marker_v_o, 1'b0);
                fill(PERIOD - 52, 0);
            end else begin
                fill(PERIOD - 1, k % 2 == 1);
            end
            if (k == 3) marker(3);
            else blk(2'b01, rnd64());
            chk("slot_flag", marker_v_o, 1'b1);
            chk("slot_err",  am_err_o, (k == 3) ? 1'b0 : 1'b1);
            chk("slot_lock", lock_v_o, (k < 7) ? 1'b1 : 1'b0);
        end
        fill(20, 1);
        chk("post_loss_lock", lock_v_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/am_lock_rx.md
# am_lock_rx

Receive-side alignment marker lock and removal for one 40GBASE-R PCS lane. It sits after block lock and descrambler bypass (alignment markers are not scrambled), before lane deskew/reorder. It finds the periodic alignment marker in the 66-bit block stream and identifies which transmit lane it carries. It locks after two correctly spaced markers, then flags every marker slot so downstream logic drops it and the 64b/66b decoder never sees it.

## Interface
Parameters:
- `HEAD_W`, 2: sync header width.
- `DATA_W`, 64: block payload width.
- `GAP_W`, 14: marker period counter width; period is 2^GAP_W valid blocks.
- `INV_MAX`, 4: consecutive bad markers that drop lock.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `valid_i` in 1: a block is presented this cycle (block lock held, gearbox output valid).
- `head_i` in HEAD_W: sync header.
- `data_i` in DATA_W: payload; byte 0 = `data_i[7:0]`.
- `valid_o` out 1: registered `valid_i`.
- `head_o` out HEAD_W: registered `head_i`.
- `data_o` out DATA_W: registered `data_i`.
- `marker_v_o` out 1: `data_o` is an alignment marker slot; drop it.
- `lock_v_o` out 1: alignment marker lock.
- `lane_o` out 2: detected transmit lane, valid while `lock_v_o` is high.
- `am_err_o` out 1: one-cycle pulse when a locked marker slot mismatches.

## Operation
- **Match function.** A block matches lane L when all of the following hold:
  - `head_i == 2'b01`.
  - Bytes 0,1,2,4,5,6 equal lane L's constants:
    - L0: 90 76 47 / 6F 89 B8
    - L1: F0 C4 E6 / 0F 3B 19
    - L2: C5 65 9B / 3A 9A 64
    - L3: A2 79 3D / 5D 86 C2
  - Bytes 3 and 7 (BIP3/BIP7) are ignored.
  - The four comparators run in parallel and are mutually exclusive.
- **Counter.**
  - `cnt` is GAP_W bits wide and cleared to 0 on the accepted marker block.
  - It increments once per valid block and wraps modulo 2^GAP_W.
  - The expected slot is the valid block arriving when `cnt == 2^GAP_W-1`, i.e. the 16384th block after the previous marker.
- **States.**
  - **SEARCH**: each valid block is compared against all lanes. On a match, `cand_lane` takes L, `cnt` is set to 0, go to CONFIRM, and the block is flagged as a marker.
  - **CONFIRM**: only the expected slot is compared.
    - Match with `cand_lane` goes to LOCKED: `lock_v_o` is set, `lane_o` takes `cand_lane`, `inv_cnt` is set to 0, and the slot is flagged.
    - Anything else (no match or a different lane) goes back to SEARCH. That block is re-evaluated as a new first marker in the same cycle.
  - **LOCKED**: every expected slot is flagged as a marker, match or not.
    - Match with `lane_o`: `inv_cnt` is set to 0.
    - Mismatch: `am_err_o` pulses and `inv_cnt` increments. On the INV_MAX-th consecutive mismatch, go to SEARCH and clear `lock_v_o`. That slot is still flagged.
- `valid_i` low: no state, counter or `inv_cnt` change, and no comparison.
- `inv_cnt` is 2 bits wide and saturates; it never wraps.

## Timing
- One-cycle latency: the block in at edge N appears on `*_o` after edge N+1.
- `marker_v_o`, `am_err_o`, `lock_v_o` and `lane_o` are registered together with that block. Whenever `valid_o` is low, `marker_v_o` and `am_err_o` are low.
- `lock_v_o` rises in the same output cycle as `marker_v_o` for the second (confirming) marker. It falls in the same output cycle as the INV_MAX-th bad slot.
- Reset values:
  - `valid_o`, `marker_v_o`, `lock_v_o`, `am_err_o` = 0.
  - `lane_o`, `head_o`, `data_o` = 0.
  - State = SEARCH, `cnt` = 0, `inv_cnt` = 0.
- Reset asserted mid-lock: the outputs above take their reset values at the next edge. No block in flight is flagged.
- A marker-like block at a non-expected position in CONFIRM or LOCKED is ignored: passed through, not flagged.

## Test plan
- **Acquire:** L2 marker, 16383 random valid blocks, then an L2 marker with random BIP bytes. Required:
  - Both markers flagged with `marker_v_o`.
  - `lock_v_o` = 1 and `lane_o` = 2 on the second marker's output cycle.
  - Data passes through unchanged after 1 cycle.
- **Wrong spacing / wrong lane:** L0 marker, then L0 after 16382 blocks (early, ignored), then L1 at the expected slot. Required:
  - `lock_v_o` stays 0.
  - The L1 block restarts CONFIRM, and an L1 marker 16384 blocks later locks with `lane_o` = 1.
- **Lose lock:** locked on L3, corrupt 3 consecutive slots, then a good slot, then corrupt 4. Required:
  - 3 `am_err_o` pulses with lock held.
  - `inv_cnt` cleared by the good slot.
  - `lock_v_o` falls on the 4th bad slot's output cycle, with all 4 slots flagged.
- **Valid gaps:** random `valid_i` deasserts during the marker period. Required: lock is still acquired at exactly 16384 valid blocks, and `valid_o` mirrors `valid_i` delayed by one cycle.
- **Header check:** a marker payload with `head_i` = 2'b10 in SEARCH. Required: not flagged, and state stays SEARCH.
- **Reset mid-operation:** `reset` pulsed for 1 cycle while LOCKED. Required:
  - All outputs are 0 the next cycle.
  - Relock needs two fresh markers.
